booth_mul_arbiter: RTL

Shares one radix-4 Booth multiplier core (8x8 signed, 16-bit product) among N_REQ requesters. It grants one request at a time and restarts the core through its active-low reset. It then streams the two operands over the core's 8-bit input bus, waits for the core's stop flag, and returns the 16-bit product to the granted requester. The block sits between the client logic and the single multiplier instance.

---
 rtl/booth_arb_pkg.sv | 23 ++
 rtl/booth_arb_pick.sv | 77 +++++++
 rtl/booth_mul_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/booth_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_arb_pkg
//  Brief    : Shared widths and FSM state encoding for the Booth multiplier
//             arbiter (booth_mul_arbiter and booth_arb_pick).
//  Revision : 1.0  initial release
// ============================================================================
package booth_arb_pkg;

   localparam int c_OP_W   = 8;    // operand width on the core input bus
   localparam int c_PROD_W = 16;   // signed product width {A,Q}
   localparam int c_ID_W   = 3;    // requester index width

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_Q = 3'd1,
      S_LOAD_M = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : booth_arb_pick
//  Brief    : Combinational winner selection among pending requests.
//             BOOTH_ARB_RR_EN defined : round-robin, search starts after the
//                                       last winner; pointer moves on grant.
//             BOOTH_ARB_RR_EN absent  : fixed priority, lowest index wins.
//  Revision : 1.0  initial release
// ============================================================================
module booth_arb_pick
   import booth_arb_pkg::*;
#(
   parameter int N_REQ = 4
)
(
`ifdef BOOTH_ARB_RR_EN
   input  logic              clk,
   input  logic              rst,
   input  logic              grant,
`endif
   input  logic [N_REQ-1:0]  req_valid,
   output logic              any,
   output logic [c_ID_W-1:0] winner
);

   assign any = |req_valid;

`ifdef BOOTH_ARB_RR_EN
   localparam logic [c_ID_W:0] c_N = (c_ID_W+1)'(N_REQ);

   // r_ptr holds the index where the next search begins
   logic [c_ID_W-1:0]  r_ptr;
   logic [2*N_REQ-1:0] w_dbl;
   logic [2*N_REQ-1:0] w_shift;
   logic [N_REQ-1:0]   w_rot;
   logic [c_ID_W-1:0]  w_off;
   logic [c_ID_W:0]    w_sum;
   logic [c_ID_W:0]    w_wrap;

   // Rotate the request vector so position 0 is the search start
   assign w_dbl   = {req_valid, req_valid};
   assign w_shift = w_dbl >> r_ptr;
   assign w_rot   = w_shift[N_REQ-1:0];

   // First pending request in rotated order
   always_comb begin
      w_off = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (w_rot[k]) w_off = c_ID_W'(k);
      end
   end

   // Undo the rotation modulo N_REQ
   assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_wrap = w_sum - c_N;
   assign winner = (w_sum >= c_N) ? w_wrap[c_ID_W-1:0] : w_sum[c_ID_W-1:0];

   // Advance the search start past the winner on every grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (grant) begin
         r_ptr <= (winner == c_ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
      end
   end
`else
   // Lowest pending index wins
   always_comb begin
      winner = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (req_valid[k]) winner = c_ID_W'(k);
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mul_arbiter
//  Brief    : Shares one 8x8 radix-4 Booth core among N_REQ requesters.
//             Grants one request, restarts the core through mul_rst, streams
//             Q then M on mul_inbus, waits for mul_stop (with watchdog) and
//             returns the 16-bit product. Optional macro BOOTH_ARB_RR_EN
//             selects round-robin arbitration instead of fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module booth_mul_arbiter
   import booth_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int WAIT_MAX = 63
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [c_OP_W*N_REQ-1:0] req_a,
   input  logic [c_OP_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   output logic [c_ID_W-1:0]       rsp_id,
   output logic [c_PROD_W-1:0]     rsp_data,
   output logic                    rsp_err,
   output logic                    mul_rst,
   output logic [c_OP_W-1:0]       mul_inbus,
   input  logic [c_PROD_W-1:0]     mul_outbus,
   input  logic                    mul_stop
);

   localparam int                c_WD_W   = $clog2(WAIT_MAX + 1);
   localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(WAIT_MAX);

   state_t                r_state;
   logic [c_OP_W-1:0]     r_b;
   logic [c_ID_W-1:0]     r_id;
   logic [c_WD_W-1:0]     r_wd;
   logic [N_REQ-1:0]      r_req_ready;
   logic                  r_rsp_valid;
   logic [c_ID_W-1:0]     r_rsp_id;
   logic [c_PROD_W-1:0]   r_rsp_data;
   logic                  r_rsp_err;
   logic                  r_mul_rst;
   logic [c_OP_W-1:0]     r_mul_inbus;

   logic                  w_any;
   logic                  w_grant;
   logic [c_ID_W-1:0]     w_winner;
   logic [c_OP_W-1:0]     w_a;
   logic [c_OP_W-1:0]     w_b;
   logic [N_REQ-1:0]      w_onehot;

   // Arbitration is only acted on while idle
   assign w_grant = (r_state == S_IDLE) && w_any;

   booth_arb_pick #(
      .N_REQ     (N_REQ)
   ) u_pick (
`ifdef BOOTH_ARB_RR_EN
      .clk       (clk),
      .rst       (rst),
      .grant     (w_grant),
`endif
      .req_valid (req_valid),
      .any       (w_any),
      .winner    (w_winner)
   );

   // Select the winner's operands and build its one-hot grant
   always_comb begin
      w_a      = '0;
      w_b      = '0;
      w_onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_winner == c_ID_W'(k)) begin
            w_a         = req_a[k*c_OP_W +: c_OP_W];
            w_b         = req_b[k*c_OP_W +: c_OP_W];
            w_onehot[k] = 1'b1;
         end
      end
   end

   // Operation sequencer: grant, load Q, load M, wait with watchdog, respond
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_b         <= '0;
         r_id        <= '0;
         r_wd        <= '0;
         r_req_ready <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_mul_rst   <= 1'b0;
         r_mul_inbus <= '0;
      end else begin
         r_req_ready <= '0;
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Core stays in reset until a request is granted
               r_mul_rst   <= 1'b0;
               r_mul_inbus <= '0;
               if (w_grant) begin
                  r_req_ready <= w_onehot;
                  r_b         <= w_b;
                  r_id        <= w_winner;
                  r_mul_rst   <= 1'b1;
                  r_mul_inbus <= w_a;
                  r_state     <= S_LOAD_Q;
               end
            end
            S_LOAD_Q: begin
               r_mul_inbus <= r_b;
               r_state     <= S_LOAD_M;
            end
            S_LOAD_M: begin
               r_mul_inbus <= '0;
               r_wd        <= '0;
               r_state     <= S_WAIT;
            end
            S_WAIT: begin
               // A real completion beats a simultaneous watchdog expiry
               if (mul_stop) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_id    <= r_id;
                  r_rsp_data  <= mul_outbus;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end else if (r_wd == c_WD_MAX) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_id    <= r_id;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            S_RESP: begin
               // Drop mul_rst so the core is re-reset during the IDLE cycle
               r_mul_rst <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_mul_rst <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign mul_rst   = r_mul_rst;
   assign mul_inbus = r_mul_inbus;

endmodule
`default_nettype wire
